// File: rtl/par2ser_8bits_pkg.sv
// rtl/par2ser_8bits_pkg.sv - shared constants and FSM encoding for the serializer/deserializer pair
package par2ser_8bits_pkg;

    localparam logic [7:0] COMMA_SYM          = 8'hBC;
    localparam int         SYNC_WORDS_DEFAULT = 4;

    typedef enum logic {
        ST_SYNC   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/par2ser_8bits.sv
// rtl/par2ser_8bits.sv - 8-bit word to MSB-first serial stream with post-reset comma sync
module par2ser_8bits
    import par2ser_8bits_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] COMMA      = COMMA_SYM,
    parameter int                    SYNC_WORDS = SYNC_WORDS_DEFAULT
) (
    input  logic                  clk_32f,
    input  logic                  reset_L,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  valid_in,
    output logic                  data_out,
    output logic                  word_start,
    output logic                  active
);

    localparam int                CNT_W     = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic [3:0]        SYNC_LAST = 4'(SYNC_WORDS);

    state_t                state;
    state_t                state_nxt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] load_word;
    logic [CNT_W-1:0]      bit_cnt;
    logic [3:0]            sync_cnt;
    logic [3:0]            sync_cnt_nxt;
    logic                  load;

    // bit_cnt resets to the last bit so the first edge after reset is a load edge
    assign load = (bit_cnt == LAST_BIT);

    always_comb begin
        state_nxt    = state;
        sync_cnt_nxt = sync_cnt;
        load_word    = COMMA;
        if (load) begin
            case (state)
                ST_SYNC: begin
                    sync_cnt_nxt = sync_cnt + 4'd1;
                    if (sync_cnt_nxt == SYNC_LAST) begin
                        state_nxt = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (valid_in) begin
                        load_word = data_in;
                    end
                end
                default: state_nxt = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk_32f or negedge reset_L) begin
        if (!reset_L) begin
            state      <= ST_SYNC;
            sync_cnt   <= 4'd0;
            shreg      <= '0;
            bit_cnt    <= LAST_BIT;
            word_start <= 1'b0;
        end else begin
            state    <= state_nxt;
            sync_cnt <= sync_cnt_nxt;
            if (load) begin
                shreg      <= load_word;
                bit_cnt    <= '0;
                word_start <= 1'b1;
            end else begin
                shreg      <= {shreg[DATA_WIDTH-2:0], 1'b0};
                bit_cnt    <= bit_cnt + 1'b1;
                word_start <= 1'b0;
            end
        end
    end

    assign data_out = shreg[DATA_WIDTH-1];
    assign active   = (state == ST_ACTIVE);

endmodule

// File: tb/tb_par2ser_8bits.sv
// tb/tb_par2ser_8bits.sv - directed and random checks of par2ser_8bits against a word-level model
module tb_par2ser_8bits;
    import par2ser_8bits_pkg::*;

    localparam int SW = 4;

    logic       clk_32f = 1'b0;
    logic       reset_L = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       data_out;
    logic       word_start;
    logic       active;

    int vectors     = 0;
    int miscompares = 0;
    int word_idx    = 0;

    par2ser_8bits #(
        .DATA_WIDTH (8),
        .COMMA      (8'hBC),
        .SYNC_WORDS (SW)
    ) dut (
        .clk_32f    (clk_32f),
        .reset_L    (reset_L),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .data_out   (data_out),
        .word_start (word_start),
        .active     (active)
    );

    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b (word %0d)", tag, obs, exp, word_idx);
        end
    endtask

    // Word k after reset is COMMA while k <= SW or when not valid; active from the SW-th load onward
    task automatic send_word(input logic [7:0] d, input logic v, input int nbits);
        logic [7:0] ew;
        logic       act;
        @(negedge clk_32f);
        data_in  = d;
        valid_in = v;
        word_idx++;
        ew  = (word_idx <= SW || !v) ? COMMA_SYM : d;
        act = (word_idx >= SW);
        for (int j = 0; j < nbits; j++) begin
            @(posedge clk_32f);
            #1;
            check("data_out", data_out, ew[7-j]);
            check("word_start", word_start, (j == 0));
            check("active", active, act);
        end
    endtask

    task automatic do_reset();
        reset_L = 1'b0;
        repeat (3) @(posedge clk_32f);
        #1;
        check("rst_data_out", data_out, 1'b0);
        check("rst_word_start", word_start, 1'b0);
        check("rst_active", active, 1'b0);
        @(posedge clk_32f);
        #2;
        reset_L  = 1'b1;
        word_idx = 0;
    endtask

    initial begin
        logic [7:0] sync_words [5];
        sync_words = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44};

        do_reset();

        // constant valid FF: four commas, then FF repeating
        for (int w = 0; w < 7; w++) send_word(8'hFF, 1'b1, 8);

        send_word(8'hA5, 1'b1, 8);
        send_word(8'h3C, 1'b0, 8);
        send_word(8'h01, 1'b1, 8);

        for (int w = 0; w < 10; w++) send_word(8'h77, 1'b0, 8);

        // BC as valid data passes unchanged
        send_word(8'hBC, 1'b1, 8);

        // abort 5A mid-word; outputs must clear without a clock edge
        send_word(8'h5A, 1'b1, 5);
        #2;
        reset_L = 1'b0;
        #1;
        check("async_data_out", data_out, 1'b0);
        check("async_word_start", word_start, 1'b0);
        check("async_active", active, 1'b0);
        do_reset();

        for (int w = 0; w < 5; w++) send_word(sync_words[w], 1'b1, 8);

        for (int w = 0; w < 6; w++) send_word(8'hC3, w[0], 8);

        for (int w = 0; w < 200; w++) begin
            send_word(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 8);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
